// File: rtl/fps_monitor_multi.sv
// Multi-channel VS frame-rate monitor: gated edge counting per channel plus a
// sequential double-dabble converter that renders one selected count as packed BCD.
module fps_monitor_multi #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_POL    = 1'b1,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       vs_in,
  input  logic [SEL_W-1:0]        sel,
  output logic [NUM_CH*CNT_W-1:0] fps,
  output logic                    meas_valid,
  output logic [NUM_CH-1:0]       stale,
  output logic [NUM_CH-1:0]       sat,
  output logic [4*DIGITS-1:0]     bcd,
  output logic                    bcd_valid,
  output logic                    bcd_busy
);

  localparam int unsigned G_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SCR_W = BCD_W + CNT_W;
  localparam int unsigned SC_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  localparam logic [G_W-1:0]   G_LAST     = G_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [SC_W-1:0]  SHIFT_LAST = SC_W'(CNT_W - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} conv_state_e;

  // Input synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0]      prev_q;
  logic [NUM_CH-1:0]      edge_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], vs_in[i]};
        prev_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  // Gate window and per-channel counters
  logic [G_W-1:0]   g_q;
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] win_cnt [NUM_CH];
  logic [NUM_CH-1:0] at_max;
  logic [NUM_CH-1:0] sat_acc_q;
  logic              gate_end;

  assign gate_end = (g_q == G_LAST);

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      edge_det[i] = EDGE_POL ? (sync_q[i][SYNC_STAGES-1] & ~prev_q[i])
                             : (~sync_q[i][SYNC_STAGES-1] & prev_q[i]);
      at_max[i]   = (cnt_q[i] == CNT_MAX);
      // Closing-window total includes an edge landing in the terminal cycle
      win_cnt[i]  = (edge_det[i] && !at_max[i]) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g_q        <= '0;
      sat_acc_q  <= '0;
      fps        <= '0;
      stale      <= '0;
      sat        <= '0;
      meas_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meas_valid <= gate_end;
      g_q        <= gate_end ? '0 : g_q + G_W'(1);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (gate_end) begin
          fps[i*CNT_W +: CNT_W] <= win_cnt[i];
          sat[i]                <= sat_acc_q[i] | (edge_det[i] & at_max[i]);
          stale[i]              <= (win_cnt[i] == '0);
          cnt_q[i]              <= '0;
          sat_acc_q[i]          <= 1'b0;
        end else if (edge_det[i]) begin
          if (at_max[i]) begin
            sat_acc_q[i] <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // BCD conversion of the selected channel
  logic [CNT_W-1:0] fps_sel;

  always_comb begin
    fps_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(sel) == i) begin
        fps_sel = fps[i*CNT_W +: CNT_W];
      end
    end
  end

  function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] t;
    t = s;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (t[CNT_W+4*d +: 4] >= 4'd5) begin
        t[CNT_W+4*d +: 4] = t[CNT_W+4*d +: 4] + 4'd3;
      end
    end
    return {t[SCR_W-2:0], 1'b0};
  endfunction

  conv_state_e      state_q;
  logic [SCR_W-1:0] scr_q;
  logic [SCR_W-1:0] scr_step;
  logic [SC_W-1:0]  sc_q;
  logic             pend_q;
  logic [SEL_W-1:0] sel_q;
  logic             conv_req;

  assign conv_req = meas_valid | (sel != sel_q);
  assign scr_step = dabble_step(scr_q);
  assign bcd_busy = (state_q == StLoad) || (state_q == StShift);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      scr_q     <= '0;
      sc_q      <= '0;
      pend_q    <= 1'b0;
      sel_q     <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      sel_q <= sel;
      if (conv_req) begin
        bcd_valid <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (conv_req) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          scr_q   <= SCR_W'(fps_sel);
          sc_q    <= '0;
          pend_q  <= pend_q | conv_req;
          state_q <= StShift;
        end
        StShift: begin
          scr_q  <= scr_step;
          sc_q   <= sc_q + SC_W'(1);
          pend_q <= pend_q | conv_req;
          if (sc_q == SHIFT_LAST) begin
            // A result overtaken by a newer request is written but not flagged valid
            bcd       <= scr_step[SCR_W-1 -: BCD_W];
            bcd_valid <= ~(pend_q | conv_req);
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (pend_q || conv_req) begin
            pend_q  <= 1'b0;
            state_q <= StLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fps_monitor_multi.sv
// Directed bench for fps_monitor_multi: three instances cover the default rising-edge
// configuration, a narrow saturating counter, and falling-edge counting.
module tb_fps_monitor_multi;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Instance A: GATE_CYCLES=1000, CNT_W=8, rising edges
  logic [2:0]  vs_a;
  logic [1:0]  sel_a;
  logic [23:0] fps_a;
  logic        meas_a, bval_a, busy_a;
  logic [2:0]  stale_a, sat_a;
  logic [11:0] bcd_a;

  fps_monitor_multi #(
    .NUM_CH(3), .GATE_CYCLES(1000), .CNT_W(8), .DIGITS(3), .SYNC_STAGES(2), .EDGE_POL(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .vs_in(vs_a), .sel(sel_a), .fps(fps_a), .meas_valid(meas_a),
    .stale(stale_a), .sat(sat_a), .bcd(bcd_a), .bcd_valid(bval_a), .bcd_busy(busy_a)
  );

  // Instance B: GATE_CYCLES=100, CNT_W=4, saturation
  logic [2:0]  vs_b;
  logic [1:0]  sel_b;
  logic [11:0] fps_b;
  logic        meas_b, bval_b, busy_b;
  logic [2:0]  stale_b, sat_b;
  logic [7:0]  bcd_b;

  fps_monitor_multi #(
    .NUM_CH(3), .GATE_CYCLES(100), .CNT_W(4), .DIGITS(2), .SYNC_STAGES(2), .EDGE_POL(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .vs_in(vs_b), .sel(sel_b), .fps(fps_b), .meas_valid(meas_b),
    .stale(stale_b), .sat(sat_b), .bcd(bcd_b), .bcd_valid(bval_b), .bcd_busy(busy_b)
  );

  // Instance C: GATE_CYCLES=200, falling edges
  logic [2:0]  vs_c;
  logic [1:0]  sel_c;
  logic [23:0] fps_c;
  logic        meas_c, bval_c, busy_c;
  logic [2:0]  stale_c, sat_c;
  logic [11:0] bcd_c;

  fps_monitor_multi #(
    .NUM_CH(3), .GATE_CYCLES(200), .CNT_W(8), .DIGITS(3), .SYNC_STAGES(2), .EDGE_POL(1'b0)
  ) u_dut_c (
    .clk(clk), .reset(reset), .vs_in(vs_c), .sel(sel_c), .fps(fps_c), .meas_valid(meas_c),
    .stale(stale_c), .sat(sat_c), .bcd(bcd_c), .bcd_valid(bval_c), .bcd_busy(busy_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    vs_a  = '0;
    vs_b  = '0;
    vs_c  = '0;
    sel_a = 2'd0;
    sel_b = 2'd1;
    sel_c = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Cycle 0 is the first cycle after reset release (gate counter at 0)
    for (int cyc = 0; cyc <= 4510; cyc++) begin
      case (cyc)
        0: begin
          check_eq("rst_fps_a", fps_a, 24'h0);
          check_eq("rst_meas_a", meas_a, 0);
          check_eq("rst_stale_a", stale_a, 0);
          check_eq("rst_bval_a", bval_a, 0);
          check_eq("rst_busy_a", busy_a, 0);
          check_eq("rst_bcd_a", bcd_a, 0);
        end
        100: begin
          check_eq("b_meas", meas_b, 1);
          check_eq("b_fps_sat15", fps_b, 12'h0F0);
          check_eq("b_sat", sat_b, 3'b010);
          check_eq("b_stale", stale_b, 3'b101);
        end
        106: begin
          check_eq("b_bcd15", bcd_b, 8'h15);
          check_eq("b_bval", bval_b, 1);
        end
        200: begin
          check_eq("b_fps_idle", fps_b, 12'h000);
          check_eq("b_stale_idle", stale_b, 3'b111);
          check_eq("b_sat_clear", sat_b, 3'b000);
          check_eq("c_fps_fall30", fps_c, {8'd30, 8'd0, 8'd0});
          check_eq("c_stale", stale_c, 3'b011);
          check_eq("c_sat", sat_c, 3'b000);
        end
        210: begin
          check_eq("c_bcd30", bcd_c, 12'h030);
          check_eq("c_bval", bval_c, 1);
        end
        400: begin
          check_eq("c_fps_rise_only", fps_c, 24'h0);
          check_eq("c_stale_rise_only", stale_c, 3'b111);
        end
        999:  check_eq("a_meas_before", meas_a, 0);
        1000: begin
          check_eq("a_meas_first", meas_a, 1);
          check_eq("a_fps_50", fps_a, {8'd0, 8'd0, 8'd50});
          check_eq("a_stale_w1", stale_a, 3'b110);
          check_eq("a_sat_w1", sat_a, 3'b000);
        end
        1001: check_eq("a_meas_pulse", meas_a, 0);
        1009: begin
          check_eq("a_busy_shift", busy_a, 1);
          check_eq("a_bval_early", bval_a, 0);
        end
        1010: begin
          check_eq("a_bcd_050", bcd_a, 12'h050);
          check_eq("a_bval_050", bval_a, 1);
          check_eq("a_busy_done", busy_a, 0);
        end
        2000: begin
          check_eq("a_fps_w2", fps_a, {8'd7, 8'd3, 8'd123});
          check_eq("a_stale_w2", stale_a, 3'b000);
          check_eq("a_sat_w2", sat_a, 3'b000);
        end
        2010: begin
          check_eq("a_bcd_123", bcd_a, 12'h123);
          check_eq("a_bval_123", bval_a, 1);
        end
        2021: begin
          check_eq("a_bval_drop", bval_a, 0);
          check_eq("a_bcd_hold", bcd_a, 12'h123);
          check_eq("a_busy_load", busy_a, 1);
        end
        2030: begin
          check_eq("a_bcd_stale_res", bcd_a, 12'h003);
          check_eq("a_bval_pending", bval_a, 0);
        end
        2040: begin
          check_eq("a_bcd_007", bcd_a, 12'h007);
          check_eq("a_bval_007", bval_a, 1);
        end
        2109: begin
          check_eq("a_bcd_hold007", bcd_a, 12'h007);
          check_eq("a_bval_sel3_drop", bval_a, 0);
        end
        2110: begin
          check_eq("a_bcd_sel_oob", bcd_a, 12'h000);
          check_eq("a_bval_sel_oob", bval_a, 1);
        end
        3000: begin
          check_eq("a_fps_w3", fps_a, 24'h0);
          check_eq("a_stale_w3", stale_a, 3'b111);
        end
        3500: check_eq("a_stale_prerst", stale_a, 3'b111);
        3501: begin
          check_eq("a_rst_fps", fps_a, 24'h0);
          check_eq("a_rst_stale", stale_a, 0);
          check_eq("a_rst_sat", sat_a, 0);
          check_eq("a_rst_meas", meas_a, 0);
          check_eq("a_rst_bcd", bcd_a, 0);
          check_eq("a_rst_bval", bval_a, 0);
          check_eq("a_rst_busy", busy_a, 0);
        end
        4500: check_eq("a_meas_postrst_early", meas_a, 0);
        4501: begin
          check_eq("a_meas_postrst", meas_a, 1);
          check_eq("a_fps_postrst", fps_a, {8'd0, 8'd0, 8'd5});
          check_eq("a_stale_postrst", stale_a, 3'b110);
        end
        default: ;
      endcase

      reset = (cyc == 3500);

      vs_a[0] = (cyc < 1000 && (cyc % 20) < 10)
             || (cyc >= 1000 && cyc < 1980 && ((cyc - 1000) % 8) < 4)
             || (cyc >= 3100 && cyc < 3400 && (cyc % 20) < 10)
             || (cyc >= 3600 && cyc < 3700 && (cyc % 20) < 10);
      // Third rise synchronises into the terminal cycle of window 2
      vs_a[1] = (cyc >= 1000 && cyc < 1005) || (cyc >= 1010 && cyc < 1015)
             || (cyc >= 1997 && cyc < 3500);
      vs_a[2] = (cyc >= 1000 && cyc < 1700 && ((cyc - 1000) % 100) < 50);

      vs_b[1] = (cyc < 90 && (cyc % 2) == 0);
      vs_c[2] = (cyc < 120 && (cyc % 4) < 2) || (cyc >= 250);

      if (cyc >= 2100)      sel_a = 2'd3;
      else if (cyc >= 2025) sel_a = 2'd2;
      else if (cyc >= 2020) sel_a = 2'd1;
      else                  sel_a = 2'd0;

      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
